// File: rtl/serial_mem_port_pkg.sv
// Shared encodings for the serial memory port: request kinds, FSM states
// and the wait-counter sizing helper.
package serial_mem_port_pkg;

  // Request kind as presented on req_kind
  typedef enum logic [1:0] {
    KIND_READ  = 2'd0,
    KIND_WRITE = 2'd1,
    KIND_FETCH = 2'd2,
    KIND_JUMP  = 2'd3
  } kind_e;

  // Transaction FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_ACK   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RDATA = 3'd5,
    ST_RESP  = 3'd6
  } state_e;

  // Wait counter width: clog2(TIMEOUT+1), at least one bit so that
  // TIMEOUT=0 (wait forever) still elaborates a legal vector.
  function automatic int wait_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_mem_port_beat_shifter.sv
// Word shifter shared by the TX and RX phases of the serial port.
// Holds one word, shifts it right by IO_BITS per beat (LSB-first) while
// filling the top with the incoming beat, and counts beats within a word.
module serial_mem_port_beat_shifter #(
  parameter int IO_BITS   = 2,
  parameter int WORD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [WORD_BITS-1:0] i_load_data,
  input  logic                 i_shift,
  input  logic [IO_BITS-1:0]   i_shift_in,
  output logic [IO_BITS-1:0]   o_beat,
  output logic [WORD_BITS-1:0] o_word_next,
  output logic                 o_last
);

  localparam int BEATS = WORD_BITS / IO_BITS;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [WORD_BITS-1:0] r_word;
  logic [CW-1:0]        r_cnt;

  // Value the word takes after one shift: drop the lowest beat, insert the
  // incoming beat at the top. After BEATS shifts the first beat in sits at
  // the LSB, which gives LSB-first reassembly for free.
  assign o_word_next = (r_word >> IO_BITS)
                     | (WORD_BITS'(i_shift_in) << (WORD_BITS - IO_BITS));
  assign o_beat      = r_word[IO_BITS-1:0];
  assign o_last      = (r_cnt == CW'(BEATS - 1));

  // Load restarts the beat count; each shift advances it and wraps on the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_word <= i_load_data;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= o_word_next;
      r_cnt  <= o_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_mem_port.sv
// Pin-level transaction port: serialises CPU requests into framed
// IO_BITS-wide address/write-data beats and collects a start-marked read
// response burst from the rx pins, with an optional wait timeout.
// IO_BITS must divide WORD_BITS and lie in 1..8.
module serial_mem_port
  import serial_mem_port_pkg::*;
#(
  parameter int IO_BITS   = 2,
  parameter int WORD_BITS = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [1:0]           i_req_kind,
  input  logic [WORD_BITS-1:0] i_req_addr,
  input  logic [WORD_BITS-1:0] i_req_wdata,
  output logic                 o_resp_valid,
  output logic                 o_resp_err,
  output logic [WORD_BITS-1:0] o_resp_data,
  output logic [IO_BITS-1:0]   o_tx_pins,
  output logic                 o_tx_frame,
  output logic                 o_tx_write,
  output logic                 o_tx_fetch,
  output logic                 o_tx_jump,
  input  logic [IO_BITS-1:0]   i_rx_pins
);

  localparam int CNT_W = wait_cnt_width(TIMEOUT);
  // Counter value seen in the final WAIT cycle before giving up
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e               r_state;
  kind_e                r_kind;
  logic [WORD_BITS-1:0] r_wdata;
  logic [IO_BITS-1:0]   r_rx_q;
  logic [CNT_W-1:0]     r_wait_cnt;

  logic [IO_BITS-1:0]   r_tx_pins;
  logic                 r_tx_frame;
  logic                 r_tx_write;
  logic                 r_tx_fetch;
  logic                 r_tx_jump;
  logic                 r_resp_valid;
  logic                 r_resp_err;
  logic [WORD_BITS-1:0] r_resp_data;

  logic                 w_sh_load;
  logic [WORD_BITS-1:0] w_sh_load_data;
  logic                 w_sh_shift;
  logic [IO_BITS-1:0]   w_sh_shift_in;
  logic [IO_BITS-1:0]   w_sh_beat;
  logic [WORD_BITS-1:0] w_sh_word_next;
  logic                 w_sh_last;

  assign o_req_ready  = (r_state == ST_IDLE);
  assign o_tx_pins    = r_tx_pins;
  assign o_tx_frame   = r_tx_frame;
  assign o_tx_write   = r_tx_write;
  assign o_tx_fetch   = r_tx_fetch;
  assign o_tx_jump    = r_tx_jump;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_data  = r_resp_data;

  // One shifter serves both directions because TX and RX phases never overlap
  serial_mem_port_beat_shifter #(
    .IO_BITS   (IO_BITS),
    .WORD_BITS (WORD_BITS)
  ) u_beat_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_sh_load),
    .i_load_data (w_sh_load_data),
    .i_shift     (w_sh_shift),
    .i_shift_in  (w_sh_shift_in),
    .o_beat      (w_sh_beat),
    .o_word_next (w_sh_word_next),
    .o_last      (w_sh_last)
  );

  // Register the rx pins; the FSM only ever looks at this registered copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_q <= '0;
    end else begin
      r_rx_q <= i_rx_pins;
    end
  end

  // Shifter control. Beat 0 of a word goes straight to the pin register,
  // so the shifter is loaded pre-shifted by one beat: its LSB beat is then
  // always the next beat to drive.
  always_comb begin
    w_sh_load      = 1'b0;
    w_sh_load_data = '0;
    w_sh_shift     = 1'b0;
    w_sh_shift_in  = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_sh_load      = 1'b1;
          w_sh_load_data = i_req_addr >> IO_BITS;
        end
      end
      ST_ADDR: begin
        if (w_sh_last) begin
          // Write data follows for WRITE; reads get an empty word and a
          // fresh beat count ready for the response burst.
          w_sh_load      = 1'b1;
          w_sh_load_data = (r_kind == KIND_WRITE) ? (r_wdata >> IO_BITS) : '0;
        end else begin
          w_sh_shift = 1'b1;
        end
      end
      ST_WDATA: begin
        w_sh_shift = !w_sh_last;
      end
      ST_RDATA: begin
        w_sh_shift    = 1'b1;
        w_sh_shift_in = r_rx_q;
      end
      default: begin
      end
    endcase
  end

  // Transaction FSM with registered pin and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_kind       <= KIND_READ;
      r_wdata      <= '0;
      r_wait_cnt   <= '0;
      r_tx_pins    <= '0;
      r_tx_frame   <= 1'b0;
      r_tx_write   <= 1'b0;
      r_tx_fetch   <= 1'b0;
      r_tx_jump    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_kind     <= kind_e'(i_req_kind);
            r_wdata    <= i_req_wdata;
            r_tx_pins  <= i_req_addr[IO_BITS-1:0];
            r_tx_frame <= 1'b1;
            r_tx_write <= (i_req_kind == KIND_WRITE);
            r_tx_fetch <= (i_req_kind == KIND_FETCH);
            r_tx_jump  <= (i_req_kind == KIND_JUMP);
            r_state    <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (w_sh_last) begin
            if (r_kind == KIND_WRITE) begin
              r_tx_pins <= r_wdata[IO_BITS-1:0];
              r_state   <= ST_WDATA;
            end else begin
              // Frame ends; the kind flags drop with it
              r_tx_pins  <= '0;
              r_tx_frame <= 1'b0;
              r_tx_fetch <= 1'b0;
              r_tx_jump  <= 1'b0;
              r_wait_cnt <= '0;
              r_state    <= ST_WAIT;
            end
          end else begin
            r_tx_pins <= w_sh_beat;
          end
        end

        ST_WDATA: begin
          if (w_sh_last) begin
            r_tx_pins    <= '0;
            r_tx_frame   <= 1'b0;
            r_tx_write   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
            r_state      <= ST_ACK;
          end else begin
            r_tx_pins <= w_sh_beat;
          end
        end

        ST_ACK: begin
          r_resp_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end

        ST_WAIT: begin
          // A start beat wins over a timeout landing in the same cycle
          if (r_rx_q[0]) begin
            r_state <= ST_RDATA;
          end else if (TIMEOUT != 0) begin
            if (r_wait_cnt == LAST_WAIT) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= '0;
              r_state      <= ST_RESP;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
        end

        ST_RDATA: begin
          if (w_sh_last) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_data  <= w_sh_word_next;
            r_state      <= ST_RESP;
          end
        end

        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_data  <= '0;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mem_port.sv
// Testbench for serial_mem_port. Four instances with different pin widths
// and timeouts share one stimulus bus; only the selected instance sees
// req_valid. Expected pin/response timelines are computed per cycle from
// the transaction rules (beat order, latency, timeout) relative to accept.
module tb_serial_mem_port;

  localparam logic [1:0] K_READ  = 2'd0;
  localparam logic [1:0] K_WRITE = 2'd1;
  localparam logic [1:0] K_FETCH = 2'd2;
  localparam logic [1:0] K_JUMP  = 2'd3;
  localparam logic [30:0] IDLE_V = {1'b1, 30'h0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          sel = 0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_kind = 2'd0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic [7:0]  rx_bus = 8'h0;
  int          n_cmp = 0;
  int          n_fail = 0;

  logic [3:0]  rdy, rv, rerr, frm, wr, fe, jp;
  logic [15:0] rd0, rd1, rd2, rd3;
  logic [1:0]  p0;
  logic [3:0]  p1;
  logic [0:0]  p2;
  logic [7:0]  p3;

  logic        m_rdy, m_rv, m_err, m_frm, m_wr, m_fe, m_jp;
  logic [15:0] m_data;
  logic [7:0]  m_pins;

  always #5 clk = ~clk;

  serial_mem_port #(.IO_BITS(2), .WORD_BITS(16), .TIMEOUT(255)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid && sel == 0), .o_req_ready(rdy[0]),
    .i_req_kind(req_kind), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(rv[0]), .o_resp_err(rerr[0]), .o_resp_data(rd0), .o_tx_pins(p0),
    .o_tx_frame(frm[0]), .o_tx_write(wr[0]), .o_tx_fetch(fe[0]), .o_tx_jump(jp[0]),
    .i_rx_pins(rx_bus[1:0]));

  serial_mem_port #(.IO_BITS(4), .WORD_BITS(16), .TIMEOUT(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid && sel == 1), .o_req_ready(rdy[1]),
    .i_req_kind(req_kind), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(rv[1]), .o_resp_err(rerr[1]), .o_resp_data(rd1), .o_tx_pins(p1),
    .o_tx_frame(frm[1]), .o_tx_write(wr[1]), .o_tx_fetch(fe[1]), .o_tx_jump(jp[1]),
    .i_rx_pins(rx_bus[3:0]));

  serial_mem_port #(.IO_BITS(1), .WORD_BITS(16), .TIMEOUT(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid && sel == 2), .o_req_ready(rdy[2]),
    .i_req_kind(req_kind), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(rv[2]), .o_resp_err(rerr[2]), .o_resp_data(rd2), .o_tx_pins(p2),
    .o_tx_frame(frm[2]), .o_tx_write(wr[2]), .o_tx_fetch(fe[2]), .o_tx_jump(jp[2]),
    .i_rx_pins(rx_bus[0:0]));

  serial_mem_port #(.IO_BITS(8), .WORD_BITS(16), .TIMEOUT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid && sel == 3), .o_req_ready(rdy[3]),
    .i_req_kind(req_kind), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(rv[3]), .o_resp_err(rerr[3]), .o_resp_data(rd3), .o_tx_pins(p3),
    .o_tx_frame(frm[3]), .o_tx_write(wr[3]), .o_tx_fetch(fe[3]), .o_tx_jump(jp[3]),
    .i_rx_pins(rx_bus[7:0]));

  always_comb begin
    m_rdy  = rdy[0];  m_rv = rv[0];  m_err = rerr[0];  m_data = rd0;
    m_frm  = frm[0];  m_wr = wr[0];  m_fe  = fe[0];    m_jp   = jp[0];
    m_pins = 8'(p0);
    case (sel)
      1: begin
        m_rdy = rdy[1]; m_rv = rv[1]; m_err = rerr[1]; m_data = rd1;
        m_frm = frm[1]; m_wr = wr[1]; m_fe = fe[1]; m_jp = jp[1]; m_pins = 8'(p1);
      end
      2: begin
        m_rdy = rdy[2]; m_rv = rv[2]; m_err = rerr[2]; m_data = rd2;
        m_frm = frm[2]; m_wr = wr[2]; m_fe = fe[2]; m_jp = jp[2]; m_pins = 8'(p2);
      end
      3: begin
        m_rdy = rdy[3]; m_rv = rv[3]; m_err = rerr[3]; m_data = rd3;
        m_frm = frm[3]; m_wr = wr[3]; m_fe = fe[3]; m_jp = jp[3]; m_pins = 8'(p3);
      end
      default: begin
      end
    endcase
  end

  function automatic int io_of(input int s);
    case (s)
      1: return 4;
      2: return 1;
      3: return 8;
      default: return 2;
    endcase
  endfunction

  function automatic int tmo_of(input int s);
    case (s)
      1: return 5;
      2: return 0;
      3: return 3;
      default: return 255;
    endcase
  endfunction

  // {ready, resp_valid, resp_err, resp_data, frame, write, fetch, jump, pins};
  // err/data only matter while resp_valid is high.
  function automatic logic [30:0] observe();
    return {m_rdy, m_rv, m_rv & m_err, (m_rv ? m_data : 16'h0),
            m_frm, m_wr, m_fe, m_jp, m_pins};
  endfunction

  // One full transaction on the selected instance, starting at a negedge in
  // IDLE. d = cycles after the last address beat before the start beat is
  // driven on rx (d=0: start beat during the last address beat).
  task automatic txn(input string name, input logic [1:0] kind, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] rdata, input int d,
                     input bit hold);
    int          io, n, tmo, resp_r, s_r;
    bit          is_wr, tmo_hit;
    logic [7:0]  mask, beat;
    logic [30:0] exp, act;
    io      = io_of(sel);
    tmo     = tmo_of(sel);
    n       = 16 / io;
    mask    = 8'((1 << io) - 1);
    is_wr   = (kind == K_WRITE);
    tmo_hit = !is_wr && (tmo != 0) && (d >= tmo);
    s_r     = n + d;
    if (is_wr)        resp_r = 2 * n + 1;
    else if (tmo_hit) resp_r = n + 1 + tmo;
    else              resp_r = 2 * n + d + 2;

    req_valid = 1'b1; req_kind = kind; req_addr = addr; req_wdata = wdata; rx_bus = 8'h0;
    @(posedge clk);
    @(negedge clk);
    // While busy either keep a request pending or scribble on the fields
    if (!hold) req_valid = 1'b0;
    req_kind  = 2'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);

    for (int r = 1; r <= resp_r + 1; r++) begin
      rx_bus = 8'($urandom) & mask & 8'hFE;
      if (!is_wr && !tmo_hit) begin
        if (r == s_r)
          rx_bus = (8'($urandom) & mask) | 8'h01;
        else if (r > s_r && r <= s_r + n)
          rx_bus = 8'(rdata >> ((r - s_r - 1) * io)) & mask;
      end

      exp = '0;
      if (r <= n) begin
        beat = 8'(addr >> ((r - 1) * io)) & mask;
        exp  = {3'b000, 16'h0, 1'b1, is_wr, (kind == K_FETCH), (kind == K_JUMP), beat};
      end else if (is_wr && r <= 2 * n) begin
        beat = 8'(wdata >> ((r - n - 1) * io)) & mask;
        exp  = {3'b000, 16'h0, 4'b1100, beat};
      end else if (r == resp_r) begin
        exp = {1'b0, 1'b1, tmo_hit, ((is_wr || tmo_hit) ? 16'h0 : rdata), 12'h0};
      end else if (r == resp_r + 1) begin
        exp = IDLE_V;
      end

      act = observe();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s sel=%0d cycle=T+%0d got=%h expected=%h", name, sel, r, act, exp);
      end
      if (r <= resp_r) @(negedge clk);
    end
    rx_bus = 8'h0;
  endtask

  task automatic test_reset();
    logic [30:0] act;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      act = observe();
      n_cmp++;
      if (act !== IDLE_V) begin
        n_fail++;
        $display("FAIL reset_state sel=%0d got=%h expected=%h", s, act, IDLE_V);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    sel = 0;
    @(negedge clk);
    act = observe();
    n_cmp++;
    if (act !== IDLE_V) begin
      n_fail++;
      $display("FAIL after_reset got=%h expected=%h", act, IDLE_V);
    end
  endtask

  task automatic test_read_basic();
    sel = 0;
    txn("read_1234", K_READ, 16'h1234, 16'($urandom), 16'hBEEF, 3, 1'b0);
  endtask

  task automatic test_write_basic();
    sel = 1;
    txn("write_00ff", K_WRITE, 16'h00FF, 16'hA5A5, 16'($urandom), 0, 1'b0);
  endtask

  task automatic test_fetch_jump_hold();
    sel = 0;
    txn("fetch_hold", K_FETCH, 16'($urandom), 16'($urandom), 16'($urandom), 2, 1'b1);
    txn("jump_after_hold", K_JUMP, 16'($urandom), 16'($urandom), 16'($urandom), 1, 1'b0);
    sel = 3;
    txn("jump_io8", K_JUMP, 16'($urandom), 16'($urandom), 16'($urandom), 0, 1'b1);
    txn("fetch_io8", K_FETCH, 16'($urandom), 16'($urandom), 16'($urandom), 1, 1'b0);
  endtask

  task automatic test_start_on_last_beat();
    sel = 0;
    txn("start_last_beat_io2", K_READ, 16'($urandom), 16'h0, 16'($urandom), 0, 1'b0);
    sel = 1;
    txn("start_last_beat_io4", K_READ, 16'($urandom), 16'h0, 16'($urandom), 0, 1'b0);
  endtask

  task automatic test_timeout();
    sel = 1;
    txn("start_just_in_time", K_READ, 16'($urandom), 16'h0, 16'($urandom), 4, 1'b0);
    txn("timeout_boundary", K_READ, 16'($urandom), 16'h0, 16'($urandom), 5, 1'b0);
    txn("timeout_fetch", K_FETCH, 16'($urandom), 16'h0, 16'($urandom), 9, 1'b0);
    txn("read_after_timeout", K_READ, 16'($urandom), 16'h0, 16'($urandom), 2, 1'b0);
  endtask

  task automatic test_wait_forever();
    sel = 2;
    txn("wait_forever", K_READ, 16'($urandom), 16'h0, 16'($urandom), 1000, 1'b0);
  endtask

  task automatic test_sweep();
    logic [1:0] kind;
    bit         hold;
    for (int s = 2; s <= 3; s++) begin
      sel = s;
      for (int i = 0; i < 12; i++) begin
        kind = 2'($urandom);
        hold = (i != 11) && ($urandom_range(0, 1) == 1);
        txn("sweep", kind, 16'($urandom), 16'($urandom), 16'($urandom),
            int'($urandom_range(0, 5)), hold);
      end
    end
  endtask

  task automatic test_reset_mid_wdata();
    logic [15:0] wd;
    logic [30:0] exp, act;
    sel = 0;
    wd  = 16'($urandom);
    req_valid = 1'b1; req_kind = K_WRITE; req_addr = 16'($urandom); req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    // second write-data beat is on the pins now
    exp = {3'b000, 16'h0, 4'b1100, (8'(wd >> 2) & 8'h03)};
    act = observe();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL mid_wdata_beat got=%h expected=%h", act, exp);
    end
    #1 rst_n = 1'b0;
    #1;
    act = observe();
    n_cmp++;
    if (act !== IDLE_V) begin
      n_fail++;
      $display("FAIL async_reset_outputs got=%h expected=%h", act, IDLE_V);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      act = observe();
      n_cmp++;
      if (act !== IDLE_V) begin
        n_fail++;
        $display("FAIL post_reset_idle cycle=%0d got=%h expected=%h", i, act, IDLE_V);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_fetch_jump_hold();
    test_start_on_last_beat();
    test_timeout();
    test_wait_forever();
    test_sweep();
    test_reset_mid_wdata();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/serial_mem_port.md
# serial_mem_port

Parametrised pin-level transaction port between the CPU core and external memory/host. Serialises a CPU request into a framed burst of `IO_BITS`-wide address and write-data beats on registered output pins. For reads it receives a start-marked, `IO_BITS`-wide response burst on registered input pins, with a wait timeout. It generalises the fixed 2-bit `tx_pins`/`rx_pins` + `tx_fetch`/`tx_jump` pin scheme of the current top level to any pin width, adds explicit framing and write support, and sits directly between the CPU and the top-level `uo_out`/`ui_in` pins.

## Interface
Parameters:
- `IO_BITS`, default 2: pin width per beat; must divide `WORD_BITS`, range 1..8.
- `WORD_BITS`, default 16: address and data width.
- `TIMEOUT`, default 255: maximum cycles in WAIT before error response; 0 = wait forever.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  port idle, request accepted when `req_valid & req_ready`.
- `req_kind`  in  2  0=READ, 1=WRITE, 2=FETCH, 3=JUMP.
- `req_addr`  in  WORD_BITS  address.
- `req_wdata`  in  WORD_BITS  write data, used for WRITE only.
- `resp_valid`  out  1  one-cycle response pulse, no backpressure.
- `resp_err`  out  1  qualifies `resp_valid`: 1 = timeout.
- `resp_data`  out  WORD_BITS  read data; 0 for WRITE ack and on error.
- `tx_pins`  out  IO_BITS  serial beat, 0 outside a frame.
- `tx_frame`  out  1  high for every address and write-data beat.
- `tx_write`, `tx_fetch`, `tx_jump`  out  1 each  kind flags, held for the whole frame; all 0 for READ.
- `rx_pins`  in  IO_BITS  serial response input.

## Operation
- N = WORD_BITS/IO_BITS beats per word, LSB-first; beat k carries bits [k·IO_BITS +: IO_BITS].
- States: IDLE → ADDR → (WRITE: WDATA → ACK) | (READ/FETCH/JUMP: WAIT → RDATA → RESP) → IDLE.
- IDLE: `req_ready`=1; on accept, latch kind/addr/wdata and go to ADDR.
- ADDR: N beats; last beat → WDATA for WRITE, else WAIT.
- WDATA: N beats of `req_wdata`, then ACK. ACK: `resp_valid`=1, `resp_err`=0, `resp_data`=0, then IDLE.
- `rx_pins` is registered into `rx_q` every cycle and the FSM only looks at `rx_q`.
- WAIT: a cycle with `rx_q[0]`=1 is the start beat; it is consumed and the FSM goes to RDATA. Otherwise the wait counter increments. If TIMEOUT≠0 and TIMEOUT WAIT cycles pass without a start, go to RESP with error.
- RDATA: the N consecutive `rx_q` values are shifted in LSB-first, then RESP.
- RESP: `resp_valid`=1 with data (or `resp_err`=1 and data 0), then IDLE.
- `req_ready`=0 in every state except IDLE; requests presented while busy are held off, not dropped.
- Wait counter width: clog2(TIMEOUT+1); it is cleared on entry to WAIT.

## Timing
- Reset (async assert, any state): FSM→IDLE, all outputs 0 except `req_ready`=1. `rx_q`=0, counters 0, shifters 0. An in-flight frame is abandoned immediately, with no partial response.
- All `tx_*` outputs are registered: accept at cycle T → first address beat and `tx_frame`=1 at T+1; last address beat at T+N.
- WRITE: data beats T+N+1..T+2N; `resp_valid` at T+2N+1; `req_ready` high at T+2N+2.
- Read: `tx_frame` drops at T+N+1 (WAIT). Start beat on `rx_pins` at cycle S appears in `rx_q` at S+1. Data on `rx_pins` runs S+1..S+N, and `resp_valid` is at S+N+2.
- A start bit present on `rx_pins` during the last address beat is legal and honoured.
- No back-to-back overlap: the minimum gap between frames is the response cycle plus one IDLE cycle.

## Structure
- `serial_mem_port_pkg`: `req_kind` encodings (KIND_READ/WRITE/FETCH/JUMP), FSM state enum.
- One sub-module `beat_shifter` (params IO_BITS, WORD_BITS): parallel load, IO_BITS-wide LSB-first shift-out and shift-in, beat counter with `last` flag. Instantiated once and shared between TX and RX, since phases never overlap.

## Test plan
- Reset mid-WDATA (IO_BITS=2): deassert `rst_n` → all tx outputs 0 the same cycle, `req_ready`=1 after release, no `resp_valid`.
- READ 0x1234, IO_BITS=2: `tx_pins` 0,1,3,0,2,0,1,0 with `tx_frame`=1 and flags 0. Then reply with start beat followed by 0xBEEF beats → `resp_valid` once, `resp_data`=0xBEEF, `resp_err`=0, exact S+N+2 latency.
- WRITE 0x00FF←0xA5A5, IO_BITS=4: 4 addr beats F,F,0,0, then 4 data beats 5,A,5,A with `tx_write`=1. `resp_valid` at T+9, `resp_data`=0.
- FETCH/JUMP: `tx_fetch`/`tx_jump` high exactly while `tx_frame`=1. `req_valid` held during busy → second request accepted only on return to IDLE.
- Timeout, TIMEOUT=5: no start bit → `resp_valid` with `resp_err`=1 and data 0 after 5 WAIT cycles. With TIMEOUT=0 the port stays in WAIT for 1000 cycles.
- IO_BITS=1 and 8 sweep: random reads/writes checked against a reference model for beat order and latency.
